// File: rtl/fpu_norm_pkg.sv
// Shared types and helpers for the FPU post-multiply normaliser and its neighbours.
package fpu_norm_pkg;

    localparam int unsigned DEF_FRAC_W = 23;
    localparam int unsigned DEF_EXP_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic                  sign;
        logic [DEF_EXP_W-1:0]  exp;
        logic [DEF_FRAC_W-1:0] frac;
    } norm_result_t;

    // All-ones value of a w-bit biased exponent (infinity / NaN code).
    function automatic logic [31:0] exp_max(input int unsigned w);
        exp_max = 32'((64'(1) << w) - 64'(1));
    endfunction

endpackage

// File: rtl/norm_step.sv
// One normalisation rule evaluation: zero, carry right-shift, hidden-bit check, or left-shift.
module norm_step
    import fpu_norm_pkg::*;
#(
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned EXP_W  = DEF_EXP_W
) (
    input  logic [FRAC_W+1:0] sig,
    input  logic [EXP_W-1:0]  exp,
    output logic [FRAC_W+1:0] sig_c,
    output logic [EXP_W-1:0]  exp_c,
    output logic [FRAC_W-1:0] frac_c,
    output logic              done_c,
    output logic              overflow_c,
    output logic              underflow_c,
    output logic              zero_c
);

    localparam int unsigned     SIG_W = FRAC_W + 2;
    localparam logic [EXP_W-1:0] EMAX = EXP_W'(exp_max(EXP_W));

    // Extra bit so the carry increment cannot wrap before the saturation test.
    logic [EXP_W:0] exp_inc;
    assign exp_inc = {1'b0, exp} + (EXP_W + 1)'(1);

    always_comb begin
        sig_c       = sig;
        exp_c       = exp;
        frac_c      = '0;
        done_c      = 1'b0;
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        zero_c      = 1'b0;

        if (sig == '0) begin
            exp_c  = '0;
            zero_c = 1'b1;
            done_c = 1'b1;
        end else if (sig[SIG_W-1]) begin
            if (exp_inc >= {1'b0, EMAX}) begin
                overflow_c = 1'b1;
                exp_c      = EMAX;
                done_c     = 1'b1;
            end else begin
                sig_c = sig >> 1;
                exp_c = exp_inc[EXP_W-1:0];
            end
        end else if (sig[SIG_W-2]) begin
            done_c = 1'b1;
            if (exp == EMAX) begin
                overflow_c = 1'b1;
            end else if (exp == '0) begin
                underflow_c = 1'b1;
            end else begin
                frac_c = sig[FRAC_W-1:0];
            end
        end else begin
            if (exp <= EXP_W'(1)) begin
                underflow_c = 1'b1;
                exp_c       = '0;
                done_c      = 1'b1;
            end else begin
                sig_c = sig << 1;
                exp_c = exp - EXP_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_normalizer_seq.sv
// Multi-cycle significand/exponent normaliser with valid/ready handshake on both sides.
module fp_normalizer_seq
    import fpu_norm_pkg::*;
#(
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [FRAC_W+1:0] in_sig,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [FRAC_W-1:0] out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              overflow,
    output logic              underflow,
    output logic              zero,
    output logic              busy
);

    localparam int unsigned SIG_W = FRAC_W + 2;

    norm_state_t       state, state_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_d;
    logic [FRAC_W-1:0] frac_d;
    logic [EXP_W-1:0]  oexp_d;
    logic              ovf_d, unf_d, zero_d;
    logic              in_ready_d, out_valid_d, busy_d;

    logic [SIG_W-1:0]  step_sig;
    logic [EXP_W-1:0]  step_exp;
    logic [FRAC_W-1:0] step_frac;
    logic              step_done, step_ovf, step_unf, step_zero;

    norm_step #(
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W)
    ) u_step (
        .sig         (sig_q),
        .exp         (exp_q),
        .sig_c       (step_sig),
        .exp_c       (step_exp),
        .frac_c      (step_frac),
        .done_c      (step_done),
        .overflow_c  (step_ovf),
        .underflow_c (step_unf),
        .zero_c      (step_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sig_q     <= '0;
            exp_q     <= '0;
            out_sign  <= 1'b0;
            out_frac  <= '0;
            out_exp   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            sig_q     <= sig_d;
            exp_q     <= exp_d;
            out_sign  <= sign_d;
            out_frac  <= frac_d;
            out_exp   <= oexp_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            zero      <= zero_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Handshake status outputs are registered decodes of the next state.
    always_comb begin
        state_d = state;
        sig_d   = sig_q;
        exp_d   = exp_q;
        sign_d  = out_sign;
        frac_d  = out_frac;
        oexp_d  = out_exp;
        ovf_d   = overflow;
        unf_d   = underflow;
        zero_d  = zero;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_sign;
                    sig_d   = in_sig;
                    exp_d   = in_exp;
                    frac_d  = '0;
                    oexp_d  = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                sig_d = step_sig;
                exp_d = step_exp;
                if (step_done) begin
                    frac_d  = step_frac;
                    oexp_d  = step_exp;
                    ovf_d   = step_ovf;
                    unf_d   = step_unf;
                    zero_d  = step_zero;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

endmodule
